gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
- Hardware response checker for 2-input logic gates: the receiving end of a gate stimulus sequence.
- Accepts (a, b, y) observation samples over a valid/ready handshake.
- Compares each y against a parameterised truth table and counts samples and mismatches.
- Tracks coverage of all four input combinations and reports done/pass once every combination has been seen.

Parameters:
- TT, 4'b0111, expected truth table; expected y = TT[{a,b}]; the default is NAND.
- CNT_W, 8, width of the sample and error counters; both saturate at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a check run
- smp_valid  input  1  sample present on smp_a/smp_b/smp_y
- smp_a  input  1  gate input a as applied
- smp_b  input  1  gate input b as applied
- smp_y  input  1  observed gate output
- smp_ready  output  1  checker accepts a sample this cycle
- busy  output  1  run in progress
- done  output  1  all four combinations covered, or run stopped on error
- pass  output  1  valid while done; 1 iff err_cnt==0
- cov  output  4  cov[{a,b}] set once that combination has been accepted
- smp_cnt  output  CNT_W  accepted samples
- err_cnt  output  CNT_W  mismatching samples
- last_err  output  3  {a,b,y} of the most recent mismatch

Behaviour:
- All outputs are registered.
- Reset (rst=1 at clk edge) gives:
  - state=IDLE
  - smp_ready=0, busy=0, done=0, pass=0
  - cov=0, smp_cnt=0, err_cnt=0, last_err=0
- Reset wins over every other event. Reset mid-run discards everything collected so far.
- States: IDLE, RUN, DONE.
- IDLE:
  - smp_ready=0; samples are ignored.
  - start=1 -> RUN. On that edge, clear cov, smp_cnt, err_cnt and last_err, and set busy=1 and smp_ready=1.
- RUN:
  - smp_ready=1. A sample is accepted on a clk edge where smp_valid && smp_ready.
  - For each accepted sample:
    - smp_cnt increments, saturating.
    - cov[{smp_a,smp_b}] is set to 1.
    - If smp_y != TT[{smp_a,smp_b}]: err_cnt increments (saturating) and last_err <= {smp_a,smp_b,smp_y}.
  - All updates are visible the cycle after acceptance.
  - If cov, including the current sample, becomes 4'b1111 -> DONE on the same edge. On that edge: smp_ready=0, busy=0, done=1, and pass = (err_cnt_next==0).
  - start during RUN is ignored.
  - Repeated combinations are accepted and checked; they only add to smp_cnt and err_cnt.
- DONE:
  - done=1 and pass are held; smp_ready=0.
  - start=1 -> RUN with all counters, cov and last_err cleared, as from IDLE.
- Saturation: at 2^CNT_W-1, further increments hold the value. No wrap.
- Latency: a sample is accepted at edge N. The counters and done reflect it after edge N; they are observable in cycle N+1.

Optional Feature:
- Macro: STOP_ON_ERR_EN.
- Defined:
  - The first mismatching sample accepted in RUN moves to DONE on the same edge, with done=1, pass=0 and smp_ready=0.
  - cov reflects only the samples accepted up to and including the failing one.
- Undefined:
  - Mismatches are counted, and the run continues until full coverage.

Test Plan:
- rst=1 two cycles, then rst=0 -> all outputs 0, state IDLE. smp_valid=1 in IDLE -> smp_ready=0, smp_cnt stays 0.
- start, then correct NAND samples (0,0,1),(0,1,1),(1,0,1),(1,1,0), one per cycle:
  - done=1 the cycle after the 4th sample.
  - pass=1, smp_cnt=4, err_cnt=0, cov=4'b1111, smp_ready=0.
- start, then (0,0,1),(1,1,1),(0,1,1),(0,1,1),(1,0,1):
  - Without STOP_ON_ERR_EN: done after the 5th sample, pass=0, err_cnt=1, smp_cnt=5, last_err=3'b111.
  - With STOP_ON_ERR_EN: done after the 2nd sample, smp_cnt=2, cov=4'b1001.
- Reset mid-run: start, 2 samples, rst=1 one cycle -> all counters 0, IDLE. A new start plus 4 correct samples -> pass=1, smp_cnt=4.
- CNT_W=2: start, then 5 x (0,0,0) followed by the other 3 correct combinations -> smp_cnt=3 and err_cnt=3 (both saturated), pass=0.
- start pulsed during RUN, with smp_valid toggling 1,0,1 -> counters unaffected by start; only the 2 valid cycles are accepted.

Source files
------------

// File: rtl/gate_response_checker.sv
// Response checker for a 2-input gate: compares observed y against truth table TT,
// counts samples/mismatches and tracks input-combination coverage. Optional: STOP_ON_ERR_EN.
module gate_response_checker #(
  parameter logic [3:0]  TT    = 4'b0111,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             smp_valid,
  input  logic             smp_a,
  input  logic             smp_b,
  input  logic             smp_y,
  output logic             smp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       last_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ready, r_busy, r_done, r_pass;
  logic [3:0]       r_cov, w_cov_nxt;
  logic [CNT_W-1:0] r_smp_cnt, w_smp_cnt_nxt;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;
  logic [2:0]       r_last_err, w_last_err_nxt;
  logic [1:0]       w_idx;
  logic             w_accept, w_mis;

  assign w_idx    = {smp_a, smp_b};
  assign w_accept = (r_state == RUN) && smp_valid && r_ready;
  assign w_mis    = (smp_y != TT[w_idx]);

  always_comb begin
    w_state_nxt    = r_state;
    w_cov_nxt      = r_cov;
    w_smp_cnt_nxt  = r_smp_cnt;
    w_err_cnt_nxt  = r_err_cnt;
    w_last_err_nxt = r_last_err;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt    = RUN;
          w_cov_nxt      = '0;
          w_smp_cnt_nxt  = '0;
          w_err_cnt_nxt  = '0;
          w_last_err_nxt = '0;
        end
      end
      RUN: begin
        if (w_accept) begin
          w_cov_nxt[w_idx] = 1'b1;
          if (r_smp_cnt != '1) w_smp_cnt_nxt = r_smp_cnt + CNT_W'(1);
          if (w_mis) begin
            if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
            w_last_err_nxt = {smp_a, smp_b, smp_y};
          end
          if (w_cov_nxt == 4'b1111) w_state_nxt = DONE;
`ifdef STOP_ON_ERR_EN
          if (w_mis) w_state_nxt = DONE;
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_cov      <= '0;
      r_smp_cnt  <= '0;
      r_err_cnt  <= '0;
      r_last_err <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready    <= (w_state_nxt == RUN);
      r_busy     <= (w_state_nxt == RUN);
      r_done     <= (w_state_nxt == DONE);
      r_pass     <= (w_state_nxt == DONE) && (w_err_cnt_nxt == '0);
      r_cov      <= w_cov_nxt;
      r_smp_cnt  <= w_smp_cnt_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_last_err <= w_last_err_nxt;
    end
  end

  assign smp_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign cov       = r_cov;
  assign smp_cnt   = r_smp_cnt;
  assign err_cnt   = r_err_cnt;
  assign last_err  = r_last_err;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed self-checking bench for gate_response_checker (NAND table, CNT_W=8 and CNT_W=2).
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst, start, smp_valid, smp_a, smp_b, smp_y;
  logic       ready, busy, done, pass;
  logic [3:0] cov;
  logic [7:0] smp_cnt, err_cnt;
  logic [2:0] last_err;
  logic       s_ready, s_busy, s_done, s_pass;
  logic [3:0] s_cov;
  logic [1:0] s_smp_cnt, s_err_cnt;
  logic [2:0] s_last_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_response_checker #(.TT(4'b0111), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y), .smp_ready(ready),
    .busy(busy), .done(done), .pass(pass), .cov(cov),
    .smp_cnt(smp_cnt), .err_cnt(err_cnt), .last_err(last_err)
  );

  gate_response_checker #(.TT(4'b0111), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y), .smp_ready(s_ready),
    .busy(s_busy), .done(s_done), .pass(s_pass), .cov(s_cov),
    .smp_cnt(s_smp_cnt), .err_cnt(s_err_cnt), .last_err(s_last_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic smp(input logic a, input logic b, input logic y);
    smp_valid = 1'b1; smp_a = a; smp_b = b; smp_y = y;
    tick();
    smp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; smp_valid = 1'b0; smp_a = 1'b0; smp_b = 1'b0; smp_y = 1'b0;
    tick(); tick();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_cov", {28'd0, cov}, 32'd0);
    chk("rst_cnts", {16'd0, smp_cnt, err_cnt}, 32'd0);
    chk("rst_last", {29'd0, last_err}, 32'd0);
    rst = 1'b0;

    // Samples in IDLE are ignored
    smp(1'b0, 1'b0, 1'b1);
    chk("idle_ready", {31'd0, ready}, 32'd0);
    chk("idle_cnt", {24'd0, smp_cnt}, 32'd0);

    // Run 1: all correct NAND samples
    do_start();
    chk("r1_ready", {31'd0, ready}, 32'd1);
    chk("r1_busy", {31'd0, busy}, 32'd1);
    smp(0, 0, 1); smp(0, 1, 1); smp(1, 0, 1);
    chk("r1_notdone", {31'd0, done}, 32'd0);
    chk("r1_cov3", {28'd0, cov}, 32'h7);
    smp(1, 1, 0);
    chk("r1_done", {31'd0, done}, 32'd1);
    chk("r1_pass", {31'd0, pass}, 32'd1);
    chk("r1_cnt", {24'd0, smp_cnt}, 32'd4);
    chk("r1_err", {24'd0, err_cnt}, 32'd0);
    chk("r1_cov", {28'd0, cov}, 32'hF);
    chk("r1_ready0", {31'd0, ready}, 32'd0);
    chk("r1_busy0", {31'd0, busy}, 32'd0);
    smp(0, 0, 0);
    chk("r1_hold_cnt", {24'd0, smp_cnt}, 32'd4);
    chk("r1_hold_pass", {31'd0, pass}, 32'd1);

    // Run 2: restart from DONE, one mismatch on (1,1)
    do_start();
    chk("r2_clr_cnt", {24'd0, smp_cnt}, 32'd0);
    chk("r2_clr_cov", {28'd0, cov}, 32'd0);
    chk("r2_clr_done", {31'd0, done}, 32'd0);
    chk("r2_ready", {31'd0, ready}, 32'd1);
    smp(0, 0, 1); smp(1, 1, 1);
    chk("r2_err1", {24'd0, err_cnt}, 32'd1);
    chk("r2_last", {29'd0, last_err}, 32'h7);
`ifdef STOP_ON_ERR_EN
    chk("r2_stop_done", {31'd0, done}, 32'd1);
    chk("r2_stop_pass", {31'd0, pass}, 32'd0);
    chk("r2_stop_cov", {28'd0, cov}, 32'h9);
    chk("r2_stop_ready", {31'd0, ready}, 32'd0);
`else
    chk("r2_run_done", {31'd0, done}, 32'd0);
`endif
    smp(0, 1, 1); smp(0, 1, 1); smp(1, 0, 1);
    chk("r2_done", {31'd0, done}, 32'd1);
    chk("r2_pass", {31'd0, pass}, 32'd0);
    chk("r2_err", {24'd0, err_cnt}, 32'd1);
    chk("r2_last_end", {29'd0, last_err}, 32'h7);
`ifdef STOP_ON_ERR_EN
    chk("r2_cnt", {24'd0, smp_cnt}, 32'd2);
`else
    chk("r2_cnt", {24'd0, smp_cnt}, 32'd5);
    chk("r2_cov", {28'd0, cov}, 32'hF);
`endif

    // Reset mid-run discards everything
    do_start();
    smp(0, 0, 1); smp(1, 1, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_cnt", {16'd0, smp_cnt, err_cnt}, 32'd0);
    chk("mr_cov", {28'd0, cov}, 32'd0);
    chk("mr_flags", {28'd0, ready, busy, done, pass}, 32'd0);
    chk("mr_last", {29'd0, last_err}, 32'd0);
    do_start();
    smp(1, 1, 0); smp(1, 0, 1); smp(0, 1, 1); smp(0, 0, 1);
    chk("mr_pass", {31'd0, pass}, 32'd1);
    chk("mr_done", {31'd0, done}, 32'd1);
    chk("mr_cnt4", {24'd0, smp_cnt}, 32'd4);

    // Saturation: 5 x (0,0,0) are mismatches
    do_start();
    for (int i = 0; i < 5; i++) smp(0, 0, 0);
`ifdef STOP_ON_ERR_EN
    chk("sat_stop_cnt", {30'd0, s_smp_cnt}, 32'd1);
    chk("sat_stop_done", {31'd0, s_done}, 32'd1);
`else
    chk("sat_mid_cnt", {30'd0, s_smp_cnt}, 32'd3);
    chk("sat_mid_err", {30'd0, s_err_cnt}, 32'd3);
    chk("wide_mid_cnt", {24'd0, smp_cnt}, 32'd5);
    chk("wide_mid_err", {24'd0, err_cnt}, 32'd5);
`endif
    smp(0, 1, 1); smp(1, 0, 1); smp(1, 1, 0);
    chk("sat_done", {31'd0, s_done}, 32'd1);
    chk("sat_pass", {31'd0, s_pass}, 32'd0);
`ifdef STOP_ON_ERR_EN
    chk("sat_cnt", {30'd0, s_smp_cnt}, 32'd1);
    chk("sat_err", {30'd0, s_err_cnt}, 32'd1);
`else
    chk("sat_cnt", {30'd0, s_smp_cnt}, 32'd3);
    chk("sat_err", {30'd0, s_err_cnt}, 32'd3);
    chk("wide_cnt", {24'd0, smp_cnt}, 32'd8);
    chk("wide_err", {24'd0, err_cnt}, 32'd5);
`endif

    // start pulsed during RUN is ignored; valid toggles 1,0,1
    do_start();
    start = 1'b1; smp(0, 0, 1);
    start = 1'b1; tick();
    start = 1'b0; smp(0, 1, 1);
    chk("sr_cnt", {24'd0, smp_cnt}, 32'd2);
    chk("sr_err", {24'd0, err_cnt}, 32'd0);
    chk("sr_cov", {28'd0, cov}, 32'h3);
    chk("sr_busy", {31'd0, busy}, 32'd1);
    chk("sr_done", {31'd0, done}, 32'd0);
    smp(1, 0, 1); smp(1, 1, 0);
    chk("sr_fin_pass", {31'd0, pass}, 32'd1);
    chk("sr_fin_cnt", {24'd0, smp_cnt}, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
